// File: rtl/svm_mac_accumulator.sv
// Signed saturating accumulate-and-decide stage: sums one vector of terms on a bias seed
// and reports the decision value, class bit and term count at the end of each vector.
module svm_mac_accumulator #(
    parameter int bitwidth = 25,
    parameter int accwidth = 32,
    parameter int cntwidth = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [bitwidth-1:0] in_data,
    input  logic                in_first,
    input  logic                in_last,
    input  logic [accwidth-1:0] bias,
    output logic                out_valid,
    output logic [accwidth-1:0] out_sum,
    output logic                out_class,
    output logic [cntwidth-1:0] out_count,
    output logic                out_err
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t                state_q, state_d;
    logic [accwidth-1:0]   acc_q, acc_d;
    logic [cntwidth-1:0]   cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [accwidth-1:0]   out_sum_q, out_sum_d;
    logic                  out_class_q, out_class_d;
    logic [cntwidth-1:0]   out_count_q, out_count_d;
    logic                  out_err_q, out_err_d;

    logic [accwidth-1:0]   term;
    logic [accwidth-1:0]   base;
    logic [accwidth-1:0]   sum;
    logic [cntwidth-1:0]   cnt_next;

    // One extra bit of headroom; differing top bits mean the true sum left the range.
    function automatic logic [accwidth-1:0] sat_add(input logic [accwidth-1:0] a,
                                                    input logic [accwidth-1:0] b);
        logic [accwidth:0] s;
        s = {a[accwidth-1], a} + {b[accwidth-1], b};
        if (s[accwidth] != s[accwidth-1])
            return s[accwidth] ? {1'b1, {(accwidth-1){1'b0}}} : {1'b0, {(accwidth-1){1'b1}}};
        return s[accwidth-1:0];
    endfunction

    // A first beat reseeds from bias regardless of state, so one adder serves both cases.
    assign term     = accwidth'($signed(in_data));
    assign base     = in_first ? bias : acc_q;
    assign sum      = sat_add(base, term);
    assign cnt_next = in_first ? cntwidth'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        out_sum_d   = out_sum_q;
        out_class_d = out_class_q;
        out_count_d = out_count_q;

        if (in_valid) begin
            if (in_first || state_q == ACC) begin
                acc_d     = sum;
                cnt_d     = cnt_next;
                out_err_d = in_first && (state_q == ACC);
                if (in_last) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = sum;
                    out_class_d = ~sum[accwidth-1];
                    out_count_d = cnt_next;
                    state_d     = IDLE;
                end else begin
                    state_d     = ACC;
                end
            end else begin
                out_err_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_class_q <= 1'b0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_class_q <= out_class_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_class = out_class_q;
    assign out_count = out_count_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_svm_mac_accumulator.sv
// Directed bench for svm_mac_accumulator: inputs change on the falling edge,
// outputs are checked 1 ns after the rising edge against hand-computed values.
module tb_svm_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [24:0] in_data;
    logic        in_first;
    logic        in_last;
    logic [31:0] bias;
    logic        out_valid;
    logic [31:0] out_sum;
    logic        out_class;
    logic [9:0]  out_count;
    logic        out_err;

    int errors = 0;
    int checks = 0;

    svm_mac_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_class (out_class),
        .out_count (out_count),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic l, input int d, input int b);
        @(negedge clk);
        in_valid = v;
        in_first = f;
        in_last  = l;
        in_data  = 25'(d);
        bias     = 32'(b);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [31:0] s, input logic c,
                                input logic [9:0] n, input logic e);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".sum"},   out_sum,   s);
        check({tag, ".class"}, out_class, c);
        check({tag, ".count"}, out_count, n);
        check({tag, ".err"},   out_err,   e);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        bias     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", out_valid, 1'b0);
        check("reset.sum",   out_sum,   32'h0);
        check("reset.class", out_class, 1'b0);
        check("reset.count", out_count, 10'd0);
        check("reset.err",   out_err,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal vector: -100 + 40 + 30 + 50 = 20
        drive(1, 1, 0, 40, -100);
        settle();
        check("norm.novalid_mid", out_valid, 1'b0);
        drive(1, 0, 0, 30, 0);
        drive(1, 0, 1, 50, 0);
        settle();
        check_result("norm", 32'd20, 1'b1, 10'd3, 1'b0);
        idle();
        settle();
        check("norm.pulse_end", out_valid, 1'b0);
        check("norm.hold_sum",  out_sum,   32'd20);

        // Negative result: 0 - 5 - 7 = -12
        drive(1, 1, 0, -5, 0);
        drive(1, 0, 1, -7, 0);
        settle();
        check_result("neg", 32'hFFFF_FFF4, 1'b0, 10'd2, 1'b0);

        // Positive saturation
        drive(1, 1, 0, 32'h000F_FFFF, 32'h7FFF_FF00);
        drive(1, 0, 1, 32'h000F_FFFF, 0);
        settle();
        check_result("satp", 32'h7FFF_FFFF, 1'b1, 10'd2, 1'b0);

        // Negative saturation
        drive(1, 1, 0, -32'h0100_0000, 32'h8000_0100);
        drive(1, 0, 1, -32'h0100_0000, 0);
        settle();
        check_result("satn", 32'h8000_0000, 1'b0, 10'd2, 1'b0);

        // Saturated accumulator recovers from clamped value: 0x7FFFFFFF - 0x1000000 + 0
        drive(1, 1, 0, 32'h000F_FFFF, 32'h7FFF_FF00);
        drive(1, 0, 1, -32'h0100_0000, 0);
        settle();
        check_result("satrec", 32'h7EFF_FFFF, 1'b1, 10'd2, 1'b0);

        // Stray beat in IDLE
        idle();
        drive(1, 0, 0, 7, 0);
        settle();
        check("stray.err",   out_err,   1'b1);
        check("stray.valid", out_valid, 1'b0);
        check("stray.hold",  out_sum,   32'h7EFF_FFFF);
        idle();
        settle();
        check("stray.err_end", out_err, 1'b0);

        // in_first mid-vector, restarting with a single-beat vector: 10 + 5
        drive(1, 1, 0, 3, 0);
        drive(1, 1, 1, 5, 10);
        settle();
        check_result("abort", 32'd15, 1'b1, 10'd1, 1'b1);

        // Back-to-back: A = 1+2+3 = 6, B = 0+9 = 9
        drive(1, 1, 0, 2, 1);
        drive(1, 0, 1, 3, 0);
        settle();
        check_result("b2b.A", 32'd6, 1'b1, 10'd2, 1'b0);
        drive(1, 1, 1, 9, 0);
        settle();
        check_result("b2b.B", 32'd9, 1'b1, 10'd1, 1'b0);
        idle();
        settle();
        check("b2b.pulse_end", out_valid, 1'b0);

        // Reset mid-vector
        drive(1, 1, 0, 100, 0);
        drive(1, 0, 0, 200, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.sum_now",   out_sum,   32'h0);
        check("rst.count_now", out_count, 10'd0);
        check("rst.class_now", out_class, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 1, 50, 0);
        settle();
        check("rst.no_valid", out_valid, 1'b0);
        check("rst.stray",    out_err,   1'b1);
        drive(1, 1, 0, 1, 5);
        drive(1, 0, 1, 2, 0);
        settle();
        check_result("rst.clean", 32'd8, 1'b1, 10'd2, 1'b0);
        idle();
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
